// File: rtl/ahb_lite_master_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_master_port_pkg
// Description : Shared AHB-Lite encodings, master FSM states and alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_lite_master_port_pkg;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;

    localparam logic [2:0] c_hsize_byte    = 3'b000;
    localparam logic [2:0] c_hsize_half    = 3'b001;
    localparam logic [2:0] c_hsize_word    = 3'b010;

    localparam logic [2:0] c_hburst_single = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Size code 3 has no legal alignment and is reported as an error.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd0:    is_aligned = 1'b1;
            2'd1:    is_aligned = ~addr_lo[0];
            2'd2:    is_aligned = (addr_lo == 2'b00);
            default: is_aligned = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_lite_master_port_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_master_port_if
// Description : Request/response handshake plus AHB-Lite master-side bus signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_lite_master_port_if;

    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic [1:0]  reqSize;
    logic        reqWrite;
    logic [31:0] reqWdata;

    logic        rspValid;
    logic        rspErr;
    logic [31:0] rspRdata;

    logic [31:0] HADDR;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        input  reqValid, reqAddr, reqSize, reqWrite, reqWdata,
        output reqReady, rspValid, rspErr, rspRdata,
        output HADDR, HSIZE, HTRANS, HWRITE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        output reqValid, reqAddr, reqSize, reqWrite, reqWdata,
        input  reqReady, rspValid, rspErr, rspRdata,
        input  HADDR, HSIZE, HTRANS, HWRITE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HREADY, HRDATA, HRESP
    );

endinterface
`default_nettype wire

// File: rtl/ahb_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lane_align
// Description : Combinational byte-lane replication for writes and lane extraction for reads.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lane_align
    import ahb_lite_master_port_pkg::*;
(
    input  wire logic [2:0]  i_hsize,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [31:0] i_wdata,
    input  wire logic [31:0] i_rdata,
    output logic      [31:0] o_wdata_rep,
    output logic      [31:0] o_rdata_ext
);

    logic [31:0] w_rdata_shift;

    assign w_rdata_shift = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_wdata_rep = i_wdata;
        o_rdata_ext = i_rdata;
        case (i_hsize)
            c_hsize_byte: begin
                o_wdata_rep = {4{i_wdata[7:0]}};
                o_rdata_ext = {24'd0, w_rdata_shift[7:0]};
            end
            c_hsize_half: begin
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_rdata_ext = {16'd0, w_rdata_shift[15:0]};
            end
            default: begin
                o_wdata_rep = i_wdata;
                o_rdata_ext = i_rdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ahb_lite_master_port.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_master_port
// Description : Single-outstanding AHB-Lite initiator issuing one SINGLE transfer per request.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_master_port
    import ahb_lite_master_port_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
)(
    input wire logic               HCLK,
    input wire logic               HRESETn,
    ahb_lite_master_port_if.master bus
);

    state_t      r_state;
    logic [1:0]  r_htrans;
    logic [31:0] r_haddr;
    logic [2:0]  r_hsize;
    logic        r_hwrite;
    logic [31:0] r_hwdata;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_accept;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_rdata_ext;

    assign w_accept = bus.reqValid && (r_state == ST_IDLE);

    ahb_lane_align u_lane_align (
        .i_hsize     (r_hsize),
        .i_addr_lo   (r_haddr[1:0]),
        .i_wdata     (r_wdata),
        .i_rdata     (bus.HRDATA),
        .o_wdata_rep (w_wdata_rep),
        .o_rdata_ext (w_rdata_ext)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_htrans    <= c_htrans_idle;
            r_haddr     <= 32'd0;
            r_hsize     <= c_hsize_byte;
            r_hwrite    <= 1'b0;
            r_hwdata    <= 32'd0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (is_aligned(bus.reqSize, bus.reqAddr[1:0])) begin
                            r_state  <= ST_ADDR;
                            r_htrans <= c_htrans_nonseq;
                            r_haddr  <= bus.reqAddr;
                            r_hsize  <= {1'b0, bus.reqSize};
                            r_hwrite <= bus.reqWrite;
                            r_wdata  <= bus.reqWdata;
                        end else begin
                            // Misaligned requests never reach the bus.
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.HREADY) begin
                        r_state  <= ST_DATA;
                        r_htrans <= c_htrans_idle;
                        r_hwdata <= w_wdata_rep;
                    end
                end
                ST_DATA: begin
                    if (bus.HREADY) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= bus.HRESP;
                        r_rsp_rdata <= (r_hwrite || bus.HRESP) ? 32'd0 : w_rdata_ext;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.reqReady  = (r_state == ST_IDLE);
    assign bus.rspValid  = r_rsp_valid;
    assign bus.rspErr    = r_rsp_err;
    assign bus.rspRdata  = r_rsp_rdata;
    assign bus.HADDR     = r_haddr;
    assign bus.HSIZE     = r_hsize;
    assign bus.HTRANS    = r_htrans;
    assign bus.HWRITE    = r_hwrite;
    assign bus.HBURST    = c_hburst_single;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = r_hwdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_master_port
// Description : Directed self-checking bench for the AHB-Lite master port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_master_port;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    ahb_lite_master_port_if bus();

    ahb_lite_master_port #(.HPROT_VAL(4'b0011)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic [1:0] size,
                             input logic write, input logic [31:0] wdata);
        bus.reqValid = 1'b1;
        bus.reqAddr  = addr;
        bus.reqSize  = size;
        bus.reqWrite = write;
        bus.reqWdata = wdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        vectors++; if (bus.HTRANS !== 2'b00) begin miscompares++; $display("FAIL rst_htrans got %h want %h", bus.HTRANS, 2'b00); end
        vectors++; if (bus.HADDR !== 32'd0) begin miscompares++; $display("FAIL rst_haddr got %h want %h", bus.HADDR, 32'd0); end
        vectors++; if ({bus.HSIZE, bus.HWRITE, bus.HWDATA} !== 36'd0) begin miscompares++; $display("FAIL rst_hsize_hwrite_hwdata got %h want %h", {bus.HSIZE, bus.HWRITE, bus.HWDATA}, 36'd0); end
        vectors++; if ({bus.rspValid, bus.rspErr, bus.rspRdata} !== 34'd0) begin miscompares++; $display("FAIL rst_rsp got %h want %h", {bus.rspValid, bus.rspErr, bus.rspRdata}, 34'd0); end
        vectors++; if (bus.reqReady !== 1'b1) begin miscompares++; $display("FAIL rst_reqready got %b want 1", bus.reqReady); end
        vectors++; if ({bus.HBURST, bus.HPROT, bus.HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin miscompares++; $display("FAIL rst_static got %h want %h", {bus.HBURST, bus.HPROT, bus.HMASTLOCK}, {3'b000, 4'b0011, 1'b0}); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_word_write();
        drive_req(32'h0000_0010, 2'd2, 1'b1, 32'hDEAD_BEEF);
        vectors++; if (bus.reqReady !== 1'b1) begin miscompares++; $display("FAIL ww_ready got %b want 1", bus.reqReady); end
        cyc();
        bus.reqValid = 1'b0;
        vectors++; if (bus.HTRANS !== 2'b10) begin miscompares++; $display("FAIL ww_htrans_addr got %h want %h", bus.HTRANS, 2'b10); end
        vectors++; if ({bus.HADDR, bus.HSIZE, bus.HWRITE} !== {32'h10, 3'b010, 1'b1}) begin miscompares++; $display("FAIL ww_ctrl got %h want %h", {bus.HADDR, bus.HSIZE, bus.HWRITE}, {32'h10, 3'b010, 1'b1}); end
        vectors++; if (bus.reqReady !== 1'b0) begin miscompares++; $display("FAIL ww_busy got %b want 0", bus.reqReady); end
        cyc();
        vectors++; if (bus.HTRANS !== 2'b00) begin miscompares++; $display("FAIL ww_htrans_data got %h want %h", bus.HTRANS, 2'b00); end
        vectors++; if (bus.HWDATA !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ww_hwdata got %h want %h", bus.HWDATA, 32'hDEAD_BEEF); end
        vectors++; if (bus.rspValid !== 1'b0) begin miscompares++; $display("FAIL ww_early_rsp got %b want 0", bus.rspValid); end
        cyc();
        vectors++; if ({bus.rspValid, bus.rspErr, bus.rspRdata} !== {1'b1, 1'b0, 32'd0}) begin miscompares++; $display("FAIL ww_rsp got %h want %h", {bus.rspValid, bus.rspErr, bus.rspRdata}, {1'b1, 1'b0, 32'd0}); end
        cyc();
        vectors++; if (bus.rspValid !== 1'b0) begin miscompares++; $display("FAIL ww_rsp_pulse got %b want 0", bus.rspValid); end
    endtask

    task automatic test_byte_read();
        drive_req(32'h0000_0013, 2'd0, 1'b0, 32'hFFFF_FFFF);
        cyc();
        bus.reqValid = 1'b0;
        vectors++; if ({bus.HTRANS, bus.HSIZE, bus.HWRITE, bus.HADDR} !== {2'b10, 3'b000, 1'b0, 32'h13}) begin miscompares++; $display("FAIL br_ctrl got %h want %h", {bus.HTRANS, bus.HSIZE, bus.HWRITE, bus.HADDR}, {2'b10, 3'b000, 1'b0, 32'h13}); end
        cyc();
        bus.HRDATA = 32'hAABB_CCDD;
        cyc();
        bus.HRDATA = 32'd0;
        vectors++; if ({bus.rspValid, bus.rspErr, bus.rspRdata} !== {1'b1, 1'b0, 32'h0000_00AA}) begin miscompares++; $display("FAIL br_rsp got %h want %h", {bus.rspValid, bus.rspErr, bus.rspRdata}, {1'b1, 1'b0, 32'h0000_00AA}); end
    endtask

    task automatic test_half_write_wait();
        drive_req(32'h0000_0022, 2'd1, 1'b1, 32'hABCD_1234);
        cyc();
        bus.reqValid = 1'b0;
        vectors++; if ({bus.HTRANS, bus.HSIZE} !== {2'b10, 3'b001}) begin miscompares++; $display("FAIL hw_ctrl got %h want %h", {bus.HTRANS, bus.HSIZE}, {2'b10, 3'b001}); end
        cyc();
        for (int i = 0; i < 4; i++) begin
            bus.HREADY = (i == 3);
            vectors++; if (bus.HWDATA !== 32'h1234_1234) begin miscompares++; $display("FAIL hw_hwdata[%0d] got %h want %h", i, bus.HWDATA, 32'h1234_1234); end
            vectors++; if (bus.rspValid !== 1'b0 || bus.HTRANS !== 2'b00) begin miscompares++; $display("FAIL hw_wait[%0d] got rsp=%b htrans=%h want rsp=0 htrans=00", i, bus.rspValid, bus.HTRANS); end
            cyc();
        end
        vectors++; if ({bus.rspValid, bus.rspErr} !== 2'b10) begin miscompares++; $display("FAIL hw_rsp got %b want 10", {bus.rspValid, bus.rspErr}); end
    endtask

    task automatic test_misaligned();
        logic [1:0]  sizes [3] = '{2'd2, 2'd1, 2'd3};
        logic [31:0] addrs [3] = '{32'h02, 32'h01, 32'h00};
        for (int i = 0; i < 3; i++) begin
            drive_req(addrs[i], sizes[i], 1'b0, 32'd0);
            bus.HRDATA = 32'h5555_5555;
            cyc();
            bus.reqValid = 1'b0;
            vectors++; if ({bus.rspValid, bus.rspErr, bus.rspRdata} !== {1'b1, 1'b1, 32'd0}) begin miscompares++; $display("FAIL mis_rsp[%0d] got %h want %h", i, {bus.rspValid, bus.rspErr, bus.rspRdata}, {1'b1, 1'b1, 32'd0}); end
            vectors++; if (bus.HTRANS !== 2'b00 || bus.reqReady !== 1'b1) begin miscompares++; $display("FAIL mis_bus[%0d] got htrans=%h ready=%b want 00 1", i, bus.HTRANS, bus.reqReady); end
            cyc();
            vectors++; if (bus.rspValid !== 1'b0 || bus.HTRANS !== 2'b00) begin miscompares++; $display("FAIL mis_after[%0d] got rsp=%b htrans=%h want 0 00", i, bus.rspValid, bus.HTRANS); end
        end
        bus.HRDATA = 32'd0;
    endtask

    task automatic test_slave_error();
        drive_req(32'h0000_0040, 2'd2, 1'b0, 32'd0);
        cyc();
        bus.reqValid = 1'b0;
        cyc();
        bus.HREADY = 1'b0; bus.HRESP = 1'b1; bus.HRDATA = 32'h1234_5678;
        cyc();
        vectors++; if (bus.rspValid !== 1'b0) begin miscompares++; $display("FAIL se_wait got %b want 0", bus.rspValid); end
        bus.HREADY = 1'b1;
        cyc();
        bus.HRESP = 1'b0; bus.HRDATA = 32'd0;
        vectors++; if ({bus.rspValid, bus.rspErr, bus.rspRdata} !== {1'b1, 1'b1, 32'd0}) begin miscompares++; $display("FAIL se_rsp got %h want %h", {bus.rspValid, bus.rspErr, bus.rspRdata}, {1'b1, 1'b1, 32'd0}); end
        vectors++; if (bus.reqReady !== 1'b1) begin miscompares++; $display("FAIL se_idle got %b want 1", bus.reqReady); end
        cyc();
        vectors++; if (bus.rspValid !== 1'b0) begin miscompares++; $display("FAIL se_single got %b want 0", bus.rspValid); end
    endtask

    task automatic test_reset_mid();
        drive_req(32'h0000_0080, 2'd2, 1'b1, 32'h55AA_55AA);
        cyc();
        bus.reqValid = 1'b0;
        cyc();
        bus.HREADY = 1'b0;
        vectors++; if (bus.HWDATA !== 32'h55AA_55AA) begin miscompares++; $display("FAIL rm_hwdata got %h want %h", bus.HWDATA, 32'h55AA_55AA); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HSIZE, bus.HWRITE} !== 70'd0) begin miscompares++; $display("FAIL rm_async got %h want 0", {bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HSIZE, bus.HWRITE}); end
        vectors++; if (bus.reqReady !== 1'b1 || bus.rspValid !== 1'b0) begin miscompares++; $display("FAIL rm_state got ready=%b rsp=%b want 1 0", bus.reqReady, bus.rspValid); end
        cyc();
        rst_n = 1'b1; bus.HREADY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            vectors++; if (bus.rspValid !== 1'b0) begin miscompares++; $display("FAIL rm_norsp[%0d] got %b want 0", i, bus.rspValid); end
        end
        drive_req(32'h0000_0006, 2'd1, 1'b0, 32'd0);
        cyc();
        bus.reqValid = 1'b0;
        cyc();
        bus.HRDATA = 32'h9876_5432;
        cyc();
        bus.HRDATA = 32'd0;
        vectors++; if ({bus.rspValid, bus.rspErr, bus.rspRdata} !== {1'b1, 1'b0, 32'h0000_9876}) begin miscompares++; $display("FAIL rm_next got %h want %h", {bus.rspValid, bus.rspErr, bus.rspRdata}, {1'b1, 1'b0, 32'h0000_9876}); end
    endtask

    task automatic test_back_to_back();
        drive_req(32'h0000_0001, 2'd0, 1'b1, 32'h0000_007E);
        cyc();
        bus.reqValid = 1'b0;
        cyc();
        vectors++; if (bus.HWDATA !== 32'h7E7E_7E7E) begin miscompares++; $display("FAIL bb_hwdata got %h want %h", bus.HWDATA, 32'h7E7E_7E7E); end
        cyc();
        drive_req(32'h0000_0004, 2'd2, 1'b0, 32'd0);
        vectors++; if (bus.rspValid !== 1'b1 || bus.reqReady !== 1'b1) begin miscompares++; $display("FAIL bb_overlap got rsp=%b ready=%b want 1 1", bus.rspValid, bus.reqReady); end
        cyc();
        bus.reqValid = 1'b0;
        vectors++; if ({bus.HTRANS, bus.HADDR} !== {2'b10, 32'h4}) begin miscompares++; $display("FAIL bb_addr got %h want %h", {bus.HTRANS, bus.HADDR}, {2'b10, 32'h4}); end
        cyc();
        bus.HRDATA = 32'h0BAD_F00D;
        cyc();
        bus.HRDATA = 32'd0;
        vectors++; if ({bus.rspValid, bus.rspErr, bus.rspRdata} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin miscompares++; $display("FAIL bb_rsp got %h want %h", {bus.rspValid, bus.rspErr, bus.rspRdata}, {1'b1, 1'b0, 32'h0BAD_F00D}); end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        bus.reqValid = 1'b0;
        bus.reqAddr  = 32'd0;
        bus.reqSize  = 2'd0;
        bus.reqWrite = 1'b0;
        bus.reqWdata = 32'd0;
        bus.HREADY   = 1'b1;
        bus.HRDATA   = 32'd0;
        bus.HRESP    = 1'b0;

        test_reset();
        test_word_write();
        test_byte_read();
        test_half_write_wait();
        test_misaligned();
        test_slave_error();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
